// File: rtl/rst_pkg.sv
// Shared types and helpers for the register status table.
// Entries store tags at TW_MAX width so the table can be built for any TW <= TW_MAX.
package rst_pkg;
    localparam int NREG_DEF = 32;
    localparam int TW_DEF   = 6;
    localparam int TW_MAX   = 16;

    typedef struct packed {
        logic              busy;
        logic [TW_MAX-1:0] tag;
    } rst_entry_t;

    function automatic logic tag_match(input logic [TW_MAX-1:0] a, input logic [TW_MAX-1:0] b);
        return a == b;
    endfunction
endpackage

// File: rtl/rst_cdb_match.sv
// Compares one entry's stored tag against every CDB broadcast.
// A hit requires the entry to be busy and the CDB to be valid.
module rst_cdb_match
    import rst_pkg::*;
#(
    parameter int NCDB = 2,
    parameter int TW   = TW_DEF
) (
    input  logic                 busy,
    input  logic [TW_MAX-1:0]    tag,
    input  logic [NCDB-1:0]      cdb_valid,
    input  logic [NCDB*TW-1:0]   cdb_tag,
    output logic [NCDB-1:0]      hit
);
    always_comb begin
        for (int c = 0; c < NCDB; c++) begin
            hit[c] = cdb_valid[c] && busy && tag_match(tag, TW_MAX'(cdb_tag[c*TW +: TW]));
        end
    end
endmodule

// File: rtl/reg_status_table_mp.sv
// Multi-port register status table: rename writes, CDB clears with read bypass,
// tag-checked regfile write enables and a registered busy-entry count.
module reg_status_table_mp
    import rst_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int TW     = TW_DEF,
    parameter int NDISP  = 2,
    parameter int NRD    = 4,
    parameter int NCDB   = 2,
    parameter int ZERO_R = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NDISP-1:0]      disp_wen,
    input  logic [NDISP*AW-1:0]   disp_waddr,
    input  logic [NDISP*TW-1:0]   disp_wtag,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*TW-1:0]     rd_tag,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*TW-1:0]    cdb_tag,
    output logic [NCDB*NREG-1:0]  wen_regfile,
    output logic [AW:0]           busy_count
);
    rst_entry_t      ent_q [NREG];
    rst_entry_t      ent_d [NREG];
    logic [NCDB-1:0] hit   [NREG];
    logic [AW:0]     cnt_d;
    logic [AW-1:0]   ra;

    for (genvar r = 0; r < NREG; r++) begin : g_entry
        rst_cdb_match #(.NCDB(NCDB), .TW(TW)) u_match (
            .busy      (ent_q[r].busy),
            .tag       (ent_q[r].tag),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .hit       (hit[r])
        );
        for (genvar c = 0; c < NCDB; c++) begin : g_wen
            assign wen_regfile[c*NREG + r] = hit[r][c];
        end
    end

    // Priority low to high as assignments proceed: CDB clear, dispatch (younger port last), flush/zero-reg.
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            ent_d[r] = ent_q[r];
            if (|hit[r]) ent_d[r].busy = 1'b0;
            for (int p = 0; p < NDISP; p++) begin
                if (disp_wen[p] && disp_waddr[p*AW +: AW] == AW'(r)) begin
                    ent_d[r].busy = 1'b1;
                    ent_d[r].tag  = TW_MAX'(disp_wtag[p*TW +: TW]);
                end
            end
            if (flush || (ZERO_R != 0 && r == 0)) ent_d[r] = '0;
            cnt_d = cnt_d + (AW+1)'(ent_d[r].busy);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) ent_q[r] <= '0;
            busy_count <= '0;
        end else begin
            ent_q      <= ent_d;
            busy_count <= cnt_d;
        end
    end

    // Reads see registered state only; a same-cycle CDB hit already counts as ready.
    always_comb begin
        ra      = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (int'(ra) < NREG) begin
                rd_busy[i]          = ent_q[ra].busy && !(|hit[ra]);
                rd_tag[i*TW +: TW]  = ent_q[ra].tag[TW-1:0];
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int a = 0; a < NCDB; a++) begin
                for (int b = a + 1; b < NCDB; b++) begin
                    assert (!(cdb_valid[a] && cdb_valid[b] &&
                              cdb_tag[a*TW +: TW] == cdb_tag[b*TW +: TW]))
                        else $error("two valid CDBs carry the same tag");
                end
            end
            for (int a = 0; a < NDISP; a++) begin
                assert (!(disp_wen[a] && ($isunknown(disp_waddr[a*AW +: AW]) ||
                                          $isunknown(disp_wtag[a*TW +: TW]))))
                    else $error("unknown value on enabled dispatch port");
                for (int b = a + 1; b < NDISP; b++) begin
                    assert (!(disp_wen[a] && disp_wen[b] &&
                              disp_wtag[a*TW +: TW] == disp_wtag[b*TW +: TW]))
                        else $error("two dispatch ports carry the same tag");
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_reg_status_table_mp.sv
// Bench for reg_status_table_mp: directed vector table, flush sequence and random traffic,
// all checked against a behavioural model through an expected-result queue.
module tb_reg_status_table_mp;
    localparam int NREG = 32;
    localparam int TW   = 6;
    localparam int NRD  = 4;
    localparam int NCDB = 2;
    localparam int AW   = 5;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [1:0]           disp_wen;
    logic [2*AW-1:0]      disp_waddr;
    logic [2*TW-1:0]      disp_wtag;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*TW-1:0]    rd_tag;
    logic [NRD-1:0]       rd_busy;
    logic [NCDB-1:0]      cdb_valid;
    logic [NCDB*TW-1:0]   cdb_tag;
    logic [NCDB*NREG-1:0] wen_regfile;
    logic [AW:0]          busy_count;

    reg_status_table_mp dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .disp_wen    (disp_wen),
        .disp_waddr  (disp_waddr),
        .disp_wtag   (disp_wtag),
        .rd_addr     (rd_addr),
        .rd_tag      (rd_tag),
        .rd_busy     (rd_busy),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .wen_regfile (wen_regfile),
        .busy_count  (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fl;
        logic [1:0] dw;
        logic [4:0] da0, da1;
        logic [5:0] dt0, dt1;
        logic [1:0] cv;
        logic [5:0] ct0, ct1;
        logic [4:0] ra0;
        logic       chk;
        logic       eb;
        logic [5:0] et;
        logic [5:0] ec;
    } vec_t;

    typedef struct packed {
        logic [NRD-1:0]       busy;
        logic [NRD*TW-1:0]    tag;
        logic [NRD*TW-1:0]    tmask;
        logic [NCDB*NREG-1:0] wen;
        logic [AW:0]          cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic          m_busy [NREG];
    logic [TW-1:0] m_tag  [NREG];
    int            m_cnt;
    int            n_cmp;
    int            n_fail;
    vec_t          tbl [14];

    function automatic vec_t mk(input logic [1:0] dw, input int da0, input int dt0,
                                input int da1, input int dt1, input logic [1:0] cv,
                                input int ct0, input int ct1, input int ra0,
                                input logic chk, input logic eb, input int et, input int ec);
        vec_t v;
        v.rst = 1'b0; v.fl = 1'b0; v.dw = dw;
        v.da0 = 5'(da0); v.dt0 = 6'(dt0); v.da1 = 5'(da1); v.dt1 = 6'(dt1);
        v.cv = cv; v.ct0 = 6'(ct0); v.ct1 = 6'(ct1); v.ra0 = 5'(ra0);
        v.chk = chk; v.eb = eb; v.et = 6'(et); v.ec = 6'(ec);
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cdb_hit(input vec_t v, input int r);
        return m_busy[r] && ((v.cv[0] && m_tag[r] == v.ct0) || (v.cv[1] && m_tag[r] == v.ct1));
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
        end
        m_cnt = 0;
    endtask

    task automatic model_step(input vec_t v);
        logic          nb [NREG];
        logic [TW-1:0] nt [NREG];
        if (v.rst || v.fl) begin
            model_clear();
        end else begin
            for (int r = 0; r < NREG; r++) begin
                nb[r] = m_busy[r] && !cdb_hit(v, r);
                nt[r] = m_tag[r];
                if (v.dw[0] && int'(v.da0) == r) begin nb[r] = 1'b1; nt[r] = v.dt0; end
                if (v.dw[1] && int'(v.da1) == r) begin nb[r] = 1'b1; nt[r] = v.dt1; end
                if (r == 0) begin nb[r] = 1'b0; nt[r] = '0; end
            end
            m_cnt = 0;
            for (int r = 0; r < NREG; r++) begin
                m_busy[r] = nb[r];
                m_tag[r]  = nt[r];
                m_cnt += int'(nb[r]);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        int   a;
        rst        = v.rst;
        flush      = v.fl;
        disp_wen   = v.dw;
        disp_waddr = {v.da1, v.da0};
        disp_wtag  = {v.dt1, v.dt0};
        cdb_valid  = v.cv;
        cdb_tag    = {v.ct1, v.ct0};
        rd_addr    = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), v.ra0};
        e = '0;
        for (int p = 0; p < NRD; p++) begin
            a = int'(rd_addr[p*AW +: AW]);
            e.busy[p]          = m_busy[a] && !cdb_hit(v, a);
            e.tag[p*TW +: TW]  = m_tag[a];
            e.tmask[p*TW +: TW] = {TW{e.busy[p]}};
        end
        for (int c = 0; c < NCDB; c++) begin
            for (int r = 0; r < NREG; r++) begin
                e.wen[c*NREG + r] = v.cv[c] && m_busy[r] &&
                                    m_tag[r] == (c == 0 ? v.ct0 : v.ct1);
            end
        end
        e.cnt = (AW+1)'(m_cnt);
        exp_q.push_back(e);

        @(negedge clk);
        got = exp_q.pop_front();
        check("rd_busy", 128'(rd_busy), 128'(got.busy));
        check("rd_tag", 128'(rd_tag & got.tmask), 128'(got.tag & got.tmask));
        check("wen_regfile", 128'(wen_regfile), 128'(got.wen));
        check("busy_count", 128'(busy_count), 128'(got.cnt));
        if (v.chk) begin
            check("tbl_rd_busy0", 128'(rd_busy[0]), 128'(v.eb));
            if (v.eb) check("tbl_rd_tag0", 128'(rd_tag[TW-1:0]), 128'(v.et));
            check("tbl_busy_count", 128'(busy_count), 128'(v.ec));
        end

        @(posedge clk);
        model_step(v);
        #1;
    endtask

    initial begin
        vec_t v;
        int   r;
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1; flush = 1'b0; disp_wen = '0; disp_waddr = '0; disp_wtag = '0;
        rd_addr = '0; cdb_valid = '0; cdb_tag = '0;

        //            dw     da0 dt0 da1 dt1 cv     ct0 ct1 ra0 chk eb  et ec
        tbl[0]  = mk(2'b00, 0,  0,  0,  0,  2'b11, 0,  1,  0,  1,  0,  0, 0);
        tbl[1]  = mk(2'b01, 5,  9,  0,  0,  2'b00, 0,  0,  5,  1,  0,  0, 0);
        tbl[2]  = mk(2'b00, 0,  0,  0,  0,  2'b00, 0,  0,  5,  1,  1,  9, 1);
        tbl[3]  = mk(2'b00, 0,  0,  0,  0,  2'b01, 9,  0,  5,  1,  0,  0, 1);
        tbl[4]  = mk(2'b00, 0,  0,  0,  0,  2'b00, 0,  0,  5,  1,  0,  0, 0);
        tbl[5]  = mk(2'b01, 7,  3,  0,  0,  2'b00, 0,  0,  7,  1,  0,  0, 0);
        tbl[6]  = mk(2'b01, 7,  4,  0,  0,  2'b00, 0,  0,  7,  1,  1,  3, 1);
        tbl[7]  = mk(2'b00, 0,  0,  0,  0,  2'b01, 3,  0,  7,  1,  1,  4, 1);
        tbl[8]  = mk(2'b01, 2,  8,  0,  0,  2'b00, 0,  0,  7,  1,  1,  4, 1);
        tbl[9]  = mk(2'b11, 2,  1,  2,  2,  2'b01, 8,  0,  2,  1,  0,  0, 2);
        tbl[10] = mk(2'b00, 0,  0,  0,  0,  2'b00, 0,  0,  2,  1,  1,  2, 2);
        tbl[11] = mk(2'b01, 0,  5,  0,  0,  2'b00, 0,  0,  0,  1,  0,  0, 2);
        tbl[12] = mk(2'b00, 0,  0,  0,  0,  2'b11, 4,  2,  0,  1,  0,  0, 2);
        tbl[13] = mk(2'b00, 0,  0,  0,  0,  2'b00, 0,  0,  2,  1,  0,  0, 0);

        repeat (2) @(posedge clk);
        model_clear();
        #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) apply(tbl[i]);

        // Fill r1..r10, then flush alongside a dispatch that must be dropped.
        for (int i = 0; i < 5; i++) apply(mk(2'b11, 1 + 2*i, 20 + 2*i, 2 + 2*i, 21 + 2*i,
                                             2'b00, 0, 0, 1 + 2*i, 0, 0, 0, 0));
        apply(mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10, 1, 1, 29, 10));
        v = mk(2'b01, 11, 6, 0, 0, 2'b00, 0, 0, 3, 1, 1, 22, 10);
        v.fl = 1'b1;
        apply(v);
        apply(mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 11, 1, 0, 0, 0));

        for (int i = 0; i < 400; i++) begin
            v = mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                   int'($urandom_range(0, 31)), 0, 2'($urandom_range(0, 3)), 0, 0,
                   int'($urandom_range(0, 31)), 0, 0, 0, 0);
            v.dt1 = v.dt0 + 6'($urandom_range(1, 63));
            r = int'($urandom_range(0, 31));
            v.ct0 = ($urandom_range(0, 9) < 7) ? m_tag[r] : 6'($urandom_range(0, 63));
            v.ct1 = v.ct0 + 6'($urandom_range(1, 63));
            v.fl  = ($urandom_range(0, 49) == 0);
            v.rst = ($urandom_range(0, 99) == 0);
            apply(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
